// File: rtl/bridge_rr_arbiter_pkg.sv
// Shared types and default widths for the N->M packing bridge and its
// round-robin front-end arbiter.
package bridge_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    LOCK = 2'd1
  } arb_state_t;

  localparam int BRIDGE_N = 8;
  localparam int BRIDGE_M = 32;

  // Number of N-bit beats that make up one M-bit bridge word.
  function automatic int beats(input int n, input int m);
    return m / n;
  endfunction

endpackage

// File: rtl/bridge_rr_arbiter_if.sv
// Handshake and data bundle between the requesters, the arbiter and the bridge.
// The arbiter uses the master view; the surrounding environment uses the slave view.
interface bridge_rr_arbiter_if
  import bridge_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int N       = BRIDGE_N,
  parameter int IDW     = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]   req_en_i;
  logic [NUM_REQ-1:0]   req_vld_i;
  logic [NUM_REQ*N-1:0] req_din;
  logic [NUM_REQ-1:0]   req_rdy_o;
  logic                 vld_o;
  logic [N-1:0]         dout;
  logic                 rdy_i;
  logic [IDW-1:0]       gnt_id_o;
  logic                 busy_o;

  modport master (
    input  req_en_i,
    input  req_vld_i,
    input  req_din,
    input  rdy_i,
    output req_rdy_o,
    output vld_o,
    output dout,
    output gnt_id_o,
    output busy_o
  );

  modport slave (
    output req_en_i,
    output req_vld_i,
    output req_din,
    output rdy_i,
    input  req_rdy_o,
    input  vld_o,
    input  dout,
    input  gnt_id_o,
    input  busy_o
  );

endinterface

// File: rtl/bridge_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     winner,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDW-1:0]       off;
  logic [IDW:0]         sum;

  // Rotating a doubled copy puts ptr at bit 0, so a plain lowest-bit
  // priority encode yields the offset from ptr; the wrap compare keeps
  // non-power-of-two NUM_REQ correct.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    any = |req;
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum > (IDW+1)'(NUM_REQ - 1)) sum = sum - (IDW+1)'(NUM_REQ);
    winner = sum[IDW-1:0];
  end

endmodule

// File: rtl/bridge_rr_arbiter.sv
// Round-robin arbiter in front of the N->M packing bridge; a grant is held
// for exactly BEATS accepted beats so each packed word has a single source.
module bridge_rr_arbiter
  import bridge_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int N       = BRIDGE_N,
  parameter int M       = BRIDGE_M,
  parameter int BEATS   = beats(N, M),
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst,
  bridge_rr_arbiter_if.master bus
);

  localparam int CW = $clog2(BEATS + 1);

  arb_state_t           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0]   cand;
  logic [IDW-1:0]       pick_id;
  logic                 pick_any;
  logic                 sel_vld;
  logic [N-1:0]         sel_din;
  logic                 accept;

  assign cand = bus.req_vld_i & bus.req_en_i;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req    (cand),
    .ptr    (ptr_q),
    .winner (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    sel_vld = 1'b0;
    sel_din = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_id_q == IDW'(k)) begin
        sel_vld = bus.req_vld_i[k];
        sel_din = bus.req_din[k*N +: N];
      end
    end
  end

  // Next-state and outputs; in LOCK the granted source passes straight
  // through, and a stalled source simply holds the grant.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_id_d      = gnt_id_q;
    beat_cnt_d    = beat_cnt_q;
    accept        = 1'b0;
    bus.vld_o     = 1'b0;
    bus.dout      = '0;
    bus.req_rdy_o = '0;
    case (state_q)
      ARB: begin
        if (pick_any) begin
          gnt_id_d   = pick_id;
          beat_cnt_d = '0;
          state_d    = LOCK;
        end
      end
      LOCK: begin
        bus.vld_o = sel_vld;
        bus.dout  = sel_din;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (gnt_id_q == IDW'(k)) bus.req_rdy_o[k] = bus.rdy_i;
        end
        accept = sel_vld & bus.rdy_i;
        if (accept) begin
          if (beat_cnt_q == CW'(BEATS - 1)) begin
            beat_cnt_d = '0;
            ptr_d      = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
            state_d    = ARB;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.gnt_id_o = gnt_id_q;
  assign bus.busy_o   = (state_q == LOCK);

  a_rdy_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.req_rdy_o));
  a_vld_in_lock : assert property (@(posedge clk) disable iff (rst)
    bus.vld_o |-> (state_q == LOCK));
  a_cnt_range : assert property (@(posedge clk) disable iff (rst)
    beat_cnt_q < CW'(BEATS));

endmodule

// File: tb/tb_bridge_rr_arbiter.sv
// Directed bench for bridge_rr_arbiter: expected beats are queued by the
// stimulus and compared by a monitor whenever a beat is accepted.
module tb_bridge_rr_arbiter;
  import bridge_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int N       = 8;
  localparam int M       = 32;
  localparam int IDW     = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   data;
  } beat_t;

  logic  clk;
  logic  rst;
  beat_t exp_q[$];
  int    tests_run;
  int    tests_failed;

  bridge_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .N(N), .IDW(IDW)) bus();

  bridge_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .N       (N),
    .M       (M)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic [3:0] vld, input logic rdy);
    bus.req_en_i  = en;
    bus.req_vld_i = vld;
    bus.rdy_i     = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushBeat(input int id);
    beat_t b;
    b.id   = IDW'(id);
    b.data = 8'hA0 + 8'(id);
    exp_q.push_back(b);
  endtask

  task automatic pushWord(input int id);
    for (int i = 0; i < 4; i++) pushBeat(id);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic monitorLoop();
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst && bus.vld_o && bus.rdy_i) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_beat: got id %0d data 0x%0h, expected no beat",
                   bus.gnt_id_o, bus.dout);
        end else begin
          b = exp_q.pop_front();
          checkOutput("beat_id", 32'(bus.gnt_id_o), 32'(b.id));
          checkOutput("beat_data", 32'(bus.dout), 32'(b.data));
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.req_din  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    applyStimulus(4'h0, 4'h0, 1'b0);
    fork
      monitorLoop();
    join_none
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) tick();
    checkOutput("t1_vld", 32'(bus.vld_o), 32'd0);
    checkOutput("t1_rdy", 32'(bus.req_rdy_o), 32'd0);
    checkOutput("t1_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("t1_gnt", 32'(bus.gnt_id_o), 32'd0);
    checkOutput("t1_dout", 32'(bus.dout), 32'd0);

    // Single source: one bubble then four beats, period five cycles.
    applyStimulus(4'hF, 4'b0100, 1'b1);
    pushWord(2);
    pushWord(2);
    pushWord(2);
    checkOutput("t2_bubble_busy", 32'(bus.busy_o), 32'd0);
    tick();
    checkOutput("t2_lock_busy", 32'(bus.busy_o), 32'd1);
    checkOutput("t2_gnt", 32'(bus.gnt_id_o), 32'd2);
    checkOutput("t2_vld", 32'(bus.vld_o), 32'd1);
    checkOutput("t2_rdy_o", 32'(bus.req_rdy_o), 32'b0100);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t2_second_bubble", 32'(bus.busy_o), 32'd0);
    tick();
    checkOutput("t2_regrant", 32'(bus.busy_o), 32'd1);
    waitDrain("t2", 40);
    applyStimulus(4'hF, 4'h0, 1'b1);
    tick();

    // All four valid from ptr 0: order 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(4'hF, 4'hF, 1'b1);
    pushWord(0);
    pushWord(1);
    pushWord(2);
    pushWord(3);
    pushWord(0);
    waitDrain("t3", 60);
    applyStimulus(4'hF, 4'h0, 1'b1);
    tick();

    // Bridge stall after two beats of the word on source 1.
    applyStimulus(4'hF, 4'hF, 1'b1);
    pushWord(1);
    tick();
    tick();
    tick();
    checkOutput("t4_gnt_pre_stall", 32'(bus.gnt_id_o), 32'd1);
    applyStimulus(4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t4_stall_vld", 32'(bus.vld_o), 32'd1);
      checkOutput("t4_stall_gnt", 32'(bus.gnt_id_o), 32'd1);
      checkOutput("t4_stall_rdy_o", 32'(bus.req_rdy_o), 32'd0);
    end
    applyStimulus(4'hF, 4'hF, 1'b1);
    tick();
    tick();
    checkOutput("t4_done_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("t4_left", 32'(exp_q.size()), 32'd0);
    applyStimulus(4'hF, 4'h0, 1'b1);
    tick();

    // Mask 1010 from ptr 2: 3,1,3,1 then en[1] dropped mid-word -> 3.
    applyStimulus(4'b1010, 4'hF, 1'b1);
    pushWord(3);
    pushWord(1);
    pushWord(3);
    pushWord(1);
    pushWord(3);
    for (int i = 0; i < 16; i++) tick();
    checkOutput("t5_lock_on_1", 32'(bus.gnt_id_o), 32'd1);
    checkOutput("t5_busy", 32'(bus.busy_o), 32'd1);
    applyStimulus(4'b1000, 4'hF, 1'b1);
    waitDrain("t5", 40);
    applyStimulus(4'b1000, 4'h0, 1'b1);
    tick();

    // Move ptr to 2, then reset mid-word on source 2.
    applyStimulus(4'hF, 4'b0010, 1'b1);
    pushWord(1);
    waitDrain("t6_setup", 20);
    applyStimulus(4'hF, 4'h0, 1'b1);
    tick();
    applyStimulus(4'hF, 4'b0100, 1'b1);
    pushBeat(2);
    pushBeat(2);
    tick();
    tick();
    tick();
    rst = 1'b1;
    applyStimulus(4'hF, 4'b0100, 1'b0);
    tick();
    checkOutput("t6_rst_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("t6_rst_gnt", 32'(bus.gnt_id_o), 32'd0);
    checkOutput("t6_rst_vld", 32'(bus.vld_o), 32'd0);
    checkOutput("t6_rst_rdy_o", 32'(bus.req_rdy_o), 32'd0);
    checkOutput("t6_rst_dout", 32'(bus.dout), 32'd0);
    checkOutput("t6_rst_left", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    applyStimulus(4'hF, 4'b1010, 1'b1);
    pushWord(1);
    tick();
    checkOutput("t6_post_rst_gnt", 32'(bus.gnt_id_o), 32'd1);
    waitDrain("t6", 20);
    applyStimulus(4'hF, 4'h0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
